// File: rtl/fp16_div_seq_pkg.sv
// ============================================================================
// fp16_pkg
// Shared definitions for the half-precision divider: format widths, special
// encodings, the controller state encoding and the flag bit positions.
// Optional build macro: FPDIV_RNE_EN (consumed by fp16_div_seq).
// ============================================================================
package fp16_pkg;

    localparam int EXPONENT = 5;
    localparam int MANTISSA = 10;
    localparam int BIAS     = 15;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } state_t;

    // flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID     = 3;
    localparam int FLAG_DIV_BY_ZERO = 2;
    localparam int FLAG_OVERFLOW    = 1;
    localparam int FLAG_UNDERFLOW   = 0;

    // One-hot flag vector with only the given bit set.
    function automatic logic [3:0] flag_mask(input int idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/fp16_div_seq_if.sv
// ============================================================================
// fp16_div_seq_if
// Operand/result handshake bundle for the fp16 divider.
//   a, b       : dividend / divisor (master -> slave)
//   in_valid   : operands valid       (master -> slave)
//   in_ready   : divider idle         (slave -> master)
//   result     : quotient             (slave -> master)
//   flags      : {invalid, div_by_zero, overflow, underflow}
//   out_valid  : result/flags valid   (slave -> master)
//   out_ready  : consumer accepts     (master -> slave)
// ============================================================================
interface fp16_div_seq_if;

    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, result, flags, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, result, flags, out_valid
    );

endinterface

// File: rtl/fp16_div_seq_exp_sign.sv
// ============================================================================
// fpdiv_exp_sign
// Combinational exponent/sign stage of the divider.
//   i_ea, i_eb : biased exponents of dividend and divisor
//   i_sa, i_sb : signs of dividend and divisor
//   o_ep       : signed Ea - Eb + BIAS, two bits wider than the exponent so
//                the full -14..44 range is representable
//   o_sp       : quotient sign
// ============================================================================
module fpdiv_exp_sign
    import fp16_pkg::*;
#(
    parameter int EXPONENT = fp16_pkg::EXPONENT,
    parameter int BIAS     = fp16_pkg::BIAS
) (
    input  logic [EXPONENT-1:0]        i_ea,
    input  logic [EXPONENT-1:0]        i_eb,
    input  logic                       i_sa,
    input  logic                       i_sb,
    output logic signed [EXPONENT+1:0] o_ep,
    output logic                       o_sp
);

    localparam logic signed [EXPONENT+1:0] BIAS_W = (EXPONENT+2)'(BIAS);

    assign o_ep = $signed({2'b00, i_ea}) - $signed({2'b00, i_eb}) + BIAS_W;
    assign o_sp = i_sa ^ i_sb;

endmodule

// File: rtl/fp16_div_seq.sv
// ============================================================================
// fp16_div_seq
// Sequential half-precision divider: one operation in flight, radix-2
// restoring mantissa division (one quotient bit per cycle), then a single
// normalise/round/range-check step.
//   clk  : clock
//   rst  : synchronous, active-high reset (aborts any operation)
//   bus  : fp16_div_seq_if.slave operand/result handshake
// Build option: FPDIV_RNE_EN defined -> round-to-nearest-even,
//               undefined           -> truncation.
// ============================================================================
module fp16_div_seq
    import fp16_pkg::*;
#(
    parameter int EXPONENT = fp16_pkg::EXPONENT,
    parameter int MANTISSA = fp16_pkg::MANTISSA,
    parameter int BIAS     = fp16_pkg::BIAS
) (
    input  logic          clk,
    input  logic          rst,
    fp16_div_seq_if.slave bus
);

    localparam int SW  = MANTISSA + 1;  // significand incl. hidden bit
    localparam int RW  = MANTISSA + 2;  // partial remainder
    localparam int QW  = MANTISSA + 4;  // quotient: 1 integer + 13 fraction bits
    localparam int EPW = EXPONENT + 2;  // signed working exponent

    localparam logic [EXPONENT-1:0]   EMAX      = '1;
    localparam logic [3:0]            CNT_START = 4'(QW - 1);
    localparam logic signed [EPW-1:0] EP_ONE    = EPW'(1);
    localparam logic signed [EPW-1:0] EP_ZERO   = '0;
    localparam logic signed [EPW-1:0] EP_INF    = EPW'((2 ** EXPONENT) - 1);

    // ---------------------------------------------------------------- state
    state_t                  r_state;
    logic                    r_sa, r_sb, r_sp;
    logic [EXPONENT-1:0]     r_ea, r_eb;
    logic [SW-1:0]           r_ma, r_mb;
    logic signed [EPW-1:0]   r_ep;
    logic [RW-1:0]           r_rem;
    logic [QW-1:0]           r_q;
    logic [3:0]              r_cnt;
    logic [15:0]             r_result;
    logic [3:0]              r_flags;
    logic                    r_out_valid;

    // ------------------------------------------------------- operand fields
    logic                    w_in_sa, w_in_sb;
    logic [EXPONENT-1:0]     w_in_ea, w_in_eb;
    logic [MANTISSA-1:0]     w_in_ma, w_in_mb;

    assign w_in_sa = bus.a[EXPONENT+MANTISSA];
    assign w_in_sb = bus.b[EXPONENT+MANTISSA];
    assign w_in_ea = bus.a[MANTISSA +: EXPONENT];
    assign w_in_eb = bus.b[MANTISSA +: EXPONENT];
    assign w_in_ma = bus.a[MANTISSA-1:0];
    assign w_in_mb = bus.b[MANTISSA-1:0];

    // ------------------------------------------------- exponent/sign stage
    logic signed [EPW-1:0]   w_ep;
    logic                    w_sp;

    fpdiv_exp_sign #(
        .EXPONENT (EXPONENT),
        .BIAS     (BIAS)
    ) u_exp_sign (
        .i_ea (r_ea),
        .i_eb (r_eb),
        .i_sa (r_sa),
        .i_sb (r_sb),
        .o_ep (w_ep),
        .o_sp (w_sp)
    );

    // --------------------------------------------------- special operands
    // Subnormals were flushed on capture, so E==0 alone means zero.
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_a_zero = (r_ea == '0);
    assign w_b_zero = (r_eb == '0);
    assign w_a_inf  = (r_ea == EMAX) && (r_ma[MANTISSA-1:0] == '0);
    assign w_b_inf  = (r_eb == EMAX) && (r_mb[MANTISSA-1:0] == '0);
    assign w_a_nan  = (r_ea == EMAX) && (r_ma[MANTISSA-1:0] != '0);
    assign w_b_nan  = (r_eb == EMAX) && (r_mb[MANTISSA-1:0] != '0);

    logic        w_special;
    logic [15:0] w_spec_result;
    logic [3:0]  w_spec_flags;

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a variable unassigned and no latch is inferred.
        w_special     = 1'b1;
        w_spec_result = QNAN;
        w_spec_flags  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_result = QNAN;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_flags = flag_mask(FLAG_INVALID);
        end else if (w_a_inf) begin
            w_spec_result = {w_sp, POS_INF[14:0]};
        end else if (w_b_zero) begin
            w_spec_result = {w_sp, POS_INF[14:0]};
            w_spec_flags  = flag_mask(FLAG_DIV_BY_ZERO);
        end else if (w_a_zero || w_b_inf) begin
            w_spec_result = {w_sp, 15'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // ------------------------------------------------ restoring divide step
    // Trial subtraction one bit wider than the remainder; its MSB is the
    // borrow, so "no borrow" means remainder >= divisor.
    logic [RW:0]   w_trial;
    logic          w_ge;
    logic [RW-1:0] w_rem_sel;

    assign w_trial   = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge      = ~w_trial[RW];
    assign w_rem_sel = w_ge ? w_trial[RW-1:0] : r_rem;

    // ---------------------------------------------- normalise and round
    // Quotient lies in (0.5, 2): at most one left shift normalises it.
    logic                  w_shift;
    logic signed [EPW-1:0] w_ep_n;
    logic signed [EPW-1:0] w_ep_r;
    logic [MANTISSA-1:0]   w_mant_r;

    assign w_shift = ~r_q[QW-1];
    assign w_ep_n  = w_shift ? (r_ep - EP_ONE) : r_ep;

`ifdef FPDIV_RNE_EN
    logic [QW-2:0]       w_qn;
    logic [MANTISSA-1:0] w_mant;
    logic                w_guard, w_sticky, w_inc;
    logic [MANTISSA:0]   w_mant_sum;

    assign w_qn       = w_shift ? {r_q[QW-3:0], 1'b0} : r_q[QW-2:0];
    assign w_mant     = w_qn[QW-2:3];
    assign w_guard    = w_qn[2];
    assign w_sticky   = (|w_qn[1:0]) | (|r_rem);
    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {{MANTISSA{1'b0}}, w_inc};
    // A carry out of the mantissa leaves the low bits zero (1.0 x 2^1).
    assign w_mant_r   = w_mant_sum[MANTISSA-1:0];
    assign w_ep_r     = w_mant_sum[MANTISSA] ? (w_ep_n + EP_ONE) : w_ep_n;
`else
    assign w_mant_r   = w_shift ? r_q[QW-3:2] : r_q[QW-2:3];
    assign w_ep_r     = w_ep_n;
`endif

    // ------------------------------------------------------------ control
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.out_valid = r_out_valid;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too; nothing here is a
            // RAM, so a full reset costs nothing and keeps sim X-free.
            r_state     <= ST_IDLE;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_sp        <= 1'b0;
            r_ea        <= '0;
            r_eb        <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_ep        <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sa    <= w_in_sa;
                        r_sb    <= w_in_sb;
                        // E==0 (zero or subnormal) is flushed to zero.
                        r_ea    <= w_in_ea;
                        r_eb    <= w_in_eb;
                        r_ma    <= (w_in_ea != '0) ? {1'b1, w_in_ma} : '0;
                        r_mb    <= (w_in_eb != '0) ? {1'b1, w_in_mb} : '0;
                        r_state <= ST_PREP;
                    end
                end

                ST_PREP: begin
                    r_sp  <= w_sp;
                    r_ep  <= w_ep;
                    r_rem <= {1'b0, r_ma};
                    r_q   <= '0;
                    r_cnt <= CNT_START;
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_flags  <= w_spec_flags;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state  <= ST_DIV;
                    end
                end

                ST_DIV: begin
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_rem <= {w_rem_sel[RW-2:0], 1'b0};
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    if (w_ep_r >= EP_INF) begin
                        r_result <= {r_sp, POS_INF[14:0]};
                        r_flags  <= flag_mask(FLAG_OVERFLOW);
                    end else if (w_ep_r <= EP_ZERO) begin
                        r_result <= {r_sp, 15'd0};
                        r_flags  <= flag_mask(FLAG_UNDERFLOW);
                    end else begin
                        r_result <= {r_sp, w_ep_r[EXPONENT-1:0], w_mant_r};
                        r_flags  <= '0;
                    end
                    r_state <= ST_DONE;
                end

                ST_DONE: begin
                    // First DONE cycle raises out_valid; result is already
                    // loaded and stays frozen until the consumer takes it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_div_seq.sv
// ============================================================================
// tb_fp16_div_seq
// Self-checking bench for fp16_div_seq: directed operations with expected
// result, flags and latency queued in a scoreboard at issue time and popped
// when the divider presents its output; plus back-pressure and reset-abort
// scenarios.
// ============================================================================
module tb_fp16_div_seq;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    localparam int LAT_NORMAL  = 17;
    localparam int LAT_SPECIAL = 2;

`ifdef FPDIV_RNE_EN
    localparam logic [15:0] TEN_OVER_THREE = 16'h42AB;
`else
    localparam logic [15:0] TEN_OVER_THREE = 16'h42AA;
`endif

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    fp16_div_seq_if bus();

    fp16_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready at a falling edge; returns 1 if seen.
    task automatic wait_in_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one division, compare the popped expectation with the output,
    // optionally stall the consumer for 5 cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic [15:0] opa, input logic [15:0] opb,
                          input logic [15:0] er, input logic [3:0] ef, input int el,
                          input bit hold);
        exp_t e;
        int   lat;
        bit   ok;
        wait_in_ready(tag, ok);
        if (!ok) return;
        bus.a        = opa;
        bus.b        = opb;
        bus.in_valid = 1'b1;
        e.res = er;
        e.flg = ef;
        e.lat = el;
        sb_q.push_back(e);
        @(posedge clk);                    // accept edge (edge 0)
        #1 bus.in_valid = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        e = sb_q.pop_front();
        if (!ok) begin
            check({tag, "_out_valid_timeout"}, 32'(bus.out_valid), 32'd1);
            return;
        end
        check({tag, "_result"},  32'(bus.result), 32'(e.res));
        check({tag, "_flags"},   32'(bus.flags),  32'(e.flg));
        check({tag, "_latency"}, 32'(lat),        32'(e.lat));

        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                // A one-cycle in_valid pulse that must be ignored outside IDLE.
                bus.in_valid = (k == 1);
                bus.a        = 16'h3C00;
                bus.b        = 16'h0000;
                @(posedge clk);
                @(negedge clk);
                check({tag, "_hold_result"},    32'(bus.result),    32'(e.res));
                check({tag, "_hold_in_ready"},  32'(bus.in_ready),  32'd0);
                check({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            end
            bus.in_valid = 1'b0;
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    // Start 6.0/2.0, assert reset in the middle of the divide loop and make
    // sure the operation is abandoned without ever producing a result.
    task automatic abort_test();
        exp_t e;
        int   hits;
        bit   ok;
        wait_in_ready("abort", ok);
        if (!ok) return;
        bus.a        = 16'h4600;
        bus.b        = 16'h4000;
        bus.in_valid = 1'b1;
        e.res = 16'h4200;
        e.flg = F_NONE;
        e.lat = LAT_NORMAL;
        sb_q.push_back(e);
        @(posedge clk);                    // accept edge
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);         // divide loop now at its 6th step
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        // The aborted operation will never complete: retire its entry.
        e = sb_q.pop_front();
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) hits++;
        end
        check("abort_no_result", 32'(hits), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result",    32'(bus.result),    32'd0);
        check("reset_flags",     32'(bus.flags),     32'd0);
        rst = 1'b0;

        // Normal path
        run_op("six_by_two",     16'h4600, 16'h4000, 16'h4200, F_NONE, LAT_NORMAL, 1'b0);
        run_op("neg_six_by_two", 16'hC600, 16'h4000, 16'hC200, F_NONE, LAT_NORMAL, 1'b0);
        run_op("neg_by_neg",     16'hC600, 16'hC000, 16'h4200, F_NONE, LAT_NORMAL, 1'b0);
        run_op("three_by_two",   16'h4200, 16'h4000, 16'h3E00, F_NONE, LAT_NORMAL, 1'b0);
        run_op("ten_by_three",   16'h4900, 16'h4200, TEN_OVER_THREE, F_NONE, LAT_NORMAL, 1'b0);
        run_op("one_by_three",   16'h3C00, 16'h4200, 16'h3555, F_NONE, LAT_NORMAL, 1'b0);

        // Special operands
        run_op("one_by_zero",    16'h3C00, 16'h0000, 16'h7C00, F_DBZ,  LAT_SPECIAL, 1'b0);
        run_op("zero_by_zero",   16'h0000, 16'h0000, 16'h7E00, F_INV,  LAT_SPECIAL, 1'b0);
        run_op("nan_by_one",     16'h7E00, 16'h3C00, 16'h7E00, F_NONE, LAT_SPECIAL, 1'b0);
        run_op("inf_by_inf",     16'h7C00, 16'hFC00, 16'h7E00, F_INV,  LAT_SPECIAL, 1'b0);
        run_op("ninf_by_two",    16'hFC00, 16'h4000, 16'hFC00, F_NONE, LAT_SPECIAL, 1'b0);
        run_op("zero_by_ntwo",   16'h0000, 16'hC000, 16'h8000, F_NONE, LAT_SPECIAL, 1'b0);
        run_op("two_by_inf",     16'h4000, 16'h7C00, 16'h0000, F_NONE, LAT_SPECIAL, 1'b0);
        run_op("subn_by_one",    16'h0001, 16'h3C00, 16'h0000, F_NONE, LAT_SPECIAL, 1'b0);
        run_op("one_by_subn",    16'h3C00, 16'h0200, 16'h7C00, F_DBZ,  LAT_SPECIAL, 1'b0);

        // Range limits
        run_op("overflow",       16'h7BFF, 16'h1400, 16'h7C00, F_OVF,  LAT_NORMAL, 1'b0);
        run_op("underflow",      16'h8400, 16'h4000, 16'h8000, F_UNF,  LAT_NORMAL, 1'b0);

        // Back-pressure, then reset abort followed by a clean operation
        run_op("hold",           16'h4600, 16'h4000, 16'h4200, F_NONE, LAT_NORMAL, 1'b1);
        run_op("after_hold",     16'h4200, 16'h4000, 16'h3E00, F_NONE, LAT_NORMAL, 1'b0);
        abort_test();
        run_op("after_abort",    16'h4600, 16'h4000, 16'h4200, F_NONE, LAT_NORMAL, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
